// File: rtl/alu_wb_arbiter_pkg.sv
// Shared widths and the writeback entry bundle for the
// writeback-port arbiter and its round-robin grant helper.
package alu_wb_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int REGIDX_WIDTH = 5;
  localparam int REGEXT_WIDTH = 2;
  localparam int DEPTH_WARP   = 4;
  localparam int REGW         = REGIDX_WIDTH + REGEXT_WIDTH;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REGW-1:0]       reg_idxw;
    logic [DEPTH_WARP-1:0] warp_id;
    logic                  wxd;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_arbiter_rr_grant.sv
// Combinational round-robin grant: first request at or after
// ptr_i, wrapping modulo N.
module rr_grant #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  always_comb begin
    // Rotating a doubled copy puts index ptr_i at bit 0.
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    any_o = |req_i;
    idx_o = sum[W-1:0];
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Round-robin arbiter sharing one registered writeback port
// between N_SRC integer-result producers.
module alu_wb_arbiter
  import alu_wb_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int SRC_W = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            in_valid_i,
  output logic [N_SRC-1:0]            in_ready_o,
  input  logic [N_SRC*XLEN-1:0]       in_wb_data_i,
  input  logic [N_SRC*REGW-1:0]       in_reg_idxw_i,
  input  logic [N_SRC*DEPTH_WARP-1:0] in_warp_id_i,
  input  logic [N_SRC-1:0]            in_wxd_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [XLEN-1:0]             out_wb_data_o,
  output logic [REGW-1:0]             out_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]       out_warp_id_o,
  output logic                        out_wxd_o,
  output logic [SRC_W-1:0]            out_src_o
);

  logic [N_SRC-1:0] gnt;
  logic [SRC_W-1:0] idx;
  logic             any;

  logic             valid_q, valid_d;
  wb_entry_t        entry_q, entry_d;
  wb_entry_t        sel;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             free;
  logic             accept;

  rr_grant #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_grant (
    .req_i (in_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    sel = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (gnt[k]) begin
        sel.data     = in_wb_data_i[k*XLEN +: XLEN];
        sel.reg_idxw = in_reg_idxw_i[k*REGW +: REGW];
        sel.warp_id  = in_warp_id_i[k*DEPTH_WARP +: DEPTH_WARP];
        sel.wxd      = in_wxd_i[k];
      end
    end
  end

  always_comb begin
    free       = !valid_q | out_ready_i;
    // No source may see ready while reset is held.
    accept     = any & free & rst_n;
    in_ready_o = accept ? gnt : '0;
    valid_d    = valid_q;
    entry_d    = entry_q;
    src_d      = src_q;
    ptr_d      = ptr_q;
    if (accept) begin
      valid_d = 1'b1;
      entry_d = sel;
      src_d   = idx;
      ptr_d   = (idx == SRC_W'(N_SRC - 1)) ? '0 : idx + SRC_W'(1);
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid_o    = valid_q;
  assign out_wb_data_o  = entry_q.data;
  assign out_reg_idxw_o = entry_q.reg_idxw;
  assign out_warp_id_o  = entry_q.warp_id;
  assign out_wxd_o      = entry_q.wxd;
  assign out_src_o      = src_q;

endmodule
